ame_num_scale: RTL and testbench

AME_NUM_SCALE -- requirements
Module: ame_num_scale

---
 rtl/ame_pkg.sv | 15 +
 rtl/ame_num_lzc.sv | 19 +
 rtl/ame_num_scale.sv | 157 +++++++++++++++
 tb/tb_ame_num_scale.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ame_pkg.sv
// Shared definitions for the ame_num block family: default frame geometry
// and the scaler FSM state encoding.
package ame_pkg;

  localparam int AME_NUM_DEF_BITS = 64;
  localparam int AME_NUM_DEF_NUM  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_EMIT = 2'd3
  } ame_state_e;

endpackage

// File: rtl/ame_num_lzc.sv
// Combinational leading-zero counter; an all-zero input reports BITS.
module ame_num_lzc #(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0]       data_i,
  output logic [$clog2(BITS):0] lzc_o
);

  localparam int OW = $clog2(BITS) + 1;

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    lzc_o = OW'(BITS);
    for (int i = 0; i < BITS; i++) begin
      lzc_o = data_i[i] ? OW'(BITS - 1 - i) : lzc_o;
    end
  end

endmodule

// File: rtl/ame_num_scale.sv
// Buffers a frame of signed words, finds the common left-shift that
// normalises the largest magnitude, then replays the frame with that shift.
module ame_num_scale
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = AME_NUM_DEF_BITS,
  parameter int COMP_DATA_NUM  = AME_NUM_DEF_NUM
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              comp_init_i,
  output logic                              comp_ready_o,
  input  logic [COMP_DATA_BITS-1:0]         comp_data_i,
  output logic                              comp_done_o,
  output logic                              comp_last_o,
  output logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_o,
  output logic [COMP_DATA_BITS-1:0]         comp_data_o
);

  localparam int              SW       = $clog2(COMP_DATA_BITS);
  localparam int              CW       = $clog2(COMP_DATA_NUM);
  localparam logic [CW-1:0]   LAST_IDX = CW'(COMP_DATA_NUM - 1);

  ame_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [COMP_DATA_BITS-1:0] m_q, m_d;
  logic [SW-1:0]             shift_q, shift_d;
  logic [COMP_DATA_BITS-1:0] buf_q [COMP_DATA_NUM];
  logic [COMP_DATA_BITS-1:0] buf_d [COMP_DATA_NUM];
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;
  logic                      last_q, last_d;
  logic [COMP_DATA_BITS-1:0] data_q, data_d;
  logic [SW-1:0]             shift_o_q, shift_o_d;

  logic                      accept;
  logic [COMP_DATA_BITS-1:0] word_mag;
  logic [SW:0]               lz;
  logic [SW-1:0]             calc_shift;
  logic [CW-1:0]             nxt_idx;

  assign accept   = comp_init_i && ready_q;
  // One's-complement magnitude: sign copies become leading zeros
  assign word_mag = comp_data_i ^ {COMP_DATA_BITS{comp_data_i[COMP_DATA_BITS-1]}};
  assign nxt_idx  = cnt_q + CW'(1);

  ame_num_lzc #(.BITS(COMP_DATA_BITS)) u_lzc (
    .data_i (m_q),
    .lzc_o  (lz)
  );

  // Shift that leaves exactly one sign bit above the largest magnitude
  always_comb begin
    if (m_q == '0) begin
      calc_shift = '0;
    end else begin
      calc_shift = SW'(lz - {{SW{1'b0}}, 1'b1});
    end
  end

  // Next-state, datapath and output-register values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    shift_d   = shift_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    last_d    = 1'b0;
    data_d    = '0;
    shift_o_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          buf_d[0] = comp_data_i;
          m_d      = word_mag;
          cnt_d    = CW'(1);
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          buf_d[cnt_q] = comp_data_i;
          m_d          = m_q | word_mag;
          cnt_d        = nxt_idx;
          state_d      = (cnt_q == LAST_IDX) ? ST_CALC : ST_LOAD;
        end else begin
          state_d      = ST_LOAD;
        end
      end
      ST_CALC: begin
        shift_d   = calc_shift;
        cnt_d     = '0;
        state_d   = ST_EMIT;
        done_d    = 1'b1;
        data_d    = buf_q[0];
        shift_o_d = calc_shift;
      end
      ST_EMIT: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d     = nxt_idx;
          done_d    = 1'b1;
          data_d    = buf_q[nxt_idx];
          shift_o_d = shift_q;
          last_d    = (nxt_idx == LAST_IDX);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  // Control state and registered outputs, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      shift_o_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      last_q    <= last_d;
      data_q    <= data_d;
      shift_o_q <= shift_o_d;
    end
  end

  // Frame buffer; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  assign comp_ready_o = ready_q;
  assign comp_done_o  = done_q;
  assign comp_last_o  = last_q;
  assign comp_data_o  = data_q;
  assign comp_shift_o = shift_o_q;

endmodule

// File: tb/tb_ame_num_scale.sv
// Directed table-driven bench for ame_num_scale with default 64-bit x 8 frames.
module tb_ame_num_scale;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        comp_init_i;
  logic        comp_ready_o;
  logic [63:0] comp_data_i;
  logic        comp_done_o;
  logic        comp_last_o;
  logic [5:0]  comp_shift_o;
  logic [63:0] comp_data_o;

  typedef struct packed {
    logic [7:0][63:0] w;
    logic [5:0]       shift;
    logic             gaps;
  } vec_t;

  vec_t tbl [7];
  int   n_checks = 0;
  int   n_fail   = 0;

  ame_num_scale dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .comp_init_i  (comp_init_i),
    .comp_ready_o (comp_ready_o),
    .comp_data_i  (comp_data_i),
    .comp_done_o  (comp_done_o),
    .comp_last_o  (comp_last_o),
    .comp_shift_o (comp_shift_o),
    .comp_data_o  (comp_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Feed one frame, then check latency, emitted data, shift and last flag
  task automatic run_frame(input int k, input vec_t v);
    for (int i = 0; i < 8; i++) begin
      if (v.gaps && i > 0) begin
        comp_init_i = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      check($sformatf("f%0d ready_load%0d", k, i), {63'd0, comp_ready_o}, 64'd1);
      comp_init_i = 1'b1;
      comp_data_i = v.w[i];
      step();
    end
    // Junk offered while busy must be ignored
    if (v.gaps) begin
      comp_init_i = 1'b1;
      comp_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      comp_init_i = 1'b0;
    end
    check($sformatf("f%0d calc_done", k), {63'd0, comp_done_o}, 64'd0);
    check($sformatf("f%0d calc_ready", k), {63'd0, comp_ready_o}, 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f%0d done%0d", k, i), {63'd0, comp_done_o}, 64'd1);
      check($sformatf("f%0d data%0d", k, i), comp_data_o, v.w[i]);
      check($sformatf("f%0d shift%0d", k, i), {58'd0, comp_shift_o}, {58'd0, v.shift});
      check($sformatf("f%0d last%0d", k, i), {63'd0, comp_last_o}, (i == 7) ? 64'd1 : 64'd0);
      check($sformatf("f%0d emit_ready%0d", k, i), {63'd0, comp_ready_o}, 64'd0);
      if (i == 7) comp_init_i = 1'b0;
      step();
    end
    check($sformatf("f%0d post_done", k), {63'd0, comp_done_o}, 64'd0);
    check($sformatf("f%0d post_ready", k), {63'd0, comp_ready_o}, 64'd1);
    check($sformatf("f%0d post_last", k), {63'd0, comp_last_o}, 64'd0);
    check($sformatf("f%0d post_data", k), comp_data_o, 64'd0);
    check($sformatf("f%0d post_shift", k), {58'd0, comp_shift_o}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[0].w[i] = 64'h0000_0000_0000_00FF;
      tbl[1].w[i] = (i < 7) ? 64'hFFFF_FFFF_FFFF_FF00 : 64'h0000_0001_0000_0000;
      tbl[2].w[i] = 64'h0;
      tbl[3].w[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      tbl[4].w[i] = (i == 3) ? 64'h8000_0000_0000_0000 : (64'h0123_4567_89AB_0000 + 64'(i));
      tbl[5].w[i] = tbl[1].w[i];
      tbl[6].w[i] = (i == 5) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFE;
    end
    tbl[0].shift = 6'd55; tbl[0].gaps = 1'b0;
    tbl[1].shift = 6'd30; tbl[1].gaps = 1'b0;
    tbl[2].shift = 6'd0;  tbl[2].gaps = 1'b0;
    tbl[3].shift = 6'd0;  tbl[3].gaps = 1'b0;
    tbl[4].shift = 6'd0;  tbl[4].gaps = 1'b0;
    tbl[5].shift = 6'd30; tbl[5].gaps = 1'b1;
    tbl[6].shift = 6'd62; tbl[6].gaps = 1'b0;

    rst_i       = 1'b1;
    comp_init_i = 1'b0;
    comp_data_i = 64'h0;
    step();
    step();
    check("rst_ready", {63'd0, comp_ready_o}, 64'd1);
    check("rst_done",  {63'd0, comp_done_o}, 64'd0);
    check("rst_last",  {63'd0, comp_last_o}, 64'd0);
    check("rst_data",  comp_data_o, 64'd0);
    check("rst_shift", {58'd0, comp_shift_o}, 64'd0);
    rst_i = 1'b0;

    run_frame(0, tbl[0]);

    // Reset on the third EMIT cycle abandons the frame
    for (int i = 0; i < 8; i++) begin
      comp_init_i = 1'b1;
      comp_data_i = tbl[1].w[i];
      step();
    end
    comp_init_i = 1'b0;
    step();
    step();
    step();
    check("emit3_done", {63'd0, comp_done_o}, 64'd1);
    check("emit3_data", comp_data_o, tbl[1].w[2]);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_done",  {63'd0, comp_done_o}, 64'd0);
    check("midrst_ready", {63'd0, comp_ready_o}, 64'd1);
    check("midrst_data",  comp_data_o, 64'd0);
    repeat (3) begin
      step();
      check("midrst_quiet", {63'd0, comp_done_o}, 64'd0);
    end

    for (int k = 0; k < 7; k++) begin
      run_frame(k, tbl[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
